// File: rtl/gamepad_reader_pkg.sv
// Shared types and constants for the NES-style gamepad reader.
package gamepad_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LO    = 3'd2,
        HI    = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Bit positions inside a frame, in the order the pad shifts them out.
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam logic [7:0] FRAME_ALL_PRESSED = 8'hFF;

endpackage

// File: rtl/gamepad_reader_sync2.sv
// Two-flop synchronizer for the asynchronous pad data line.
module gamepad_reader_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values simply move the sample one stage along.
    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // Synchronizer flops, preset to the idle level of the line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/gamepad_reader.sv
// Polls an NES-style serial pad, debounces over two matching frames and
// maps the result onto the snake game's button inputs.
module gamepad_reader
    import gamepad_reader_pkg::*;
#(
    parameter int unsigned HALF_CYCLES = 150
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_poll,
    input  logic       i_pad_data,
    output logic       o_pad_latch,
    output logic       o_pad_clk,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic       o_pause,
    output logic       o_restart,
    output logic       o_present,
    output logic       o_frame,
    output logic [7:0] o_buttons
);

    localparam int unsigned CNT_W = $clog2(2 * HALF_CYCLES);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

    logic data_sync;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       prev_q, prev_d;
    logic [7:0]       stable_q, stable_d;
    logic             present_q, present_d;
    logic             pause_q, pause_d;
    logic             frame_q, frame_d;
    logic [7:0]       buttons_q, buttons_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             left_q, left_d;
    logic             right_q, right_d;
    logic             restart_q, restart_d;

    gamepad_reader_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_pad_data),
        .o_q   (data_sync)
    );

    // State register plus all datapath flops; reset aborts any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            present_q <= 1'b0;
            pause_q   <= 1'b0;
            frame_q   <= 1'b0;
            buttons_q <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            present_q <= present_d;
            pause_q   <= pause_d;
            frame_q   <= frame_d;
            buttons_q <= buttons_d;
            up_q      <= up_d;
            down_q    <= down_d;
            left_q    <= left_d;
            right_q   <= right_d;
            restart_q <= restart_d;
        end
    end

    // Next-state logic: pace latch and pad-clock phases, capture one bit per LO phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (i_poll) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = LO;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LO: begin
                if (cnt_q == HALF_LAST) begin
                    shift_d[bit_q] = ~data_sync;
                    state_d        = HI;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = LO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pad pin outputs decoded from the current state.
    always_comb begin
        o_pad_latch = (state_q == LATCH);
        o_pad_clk   = (state_q != LO);
    end

    // Frame evaluation in DONE: presence, two-frame debounce and pause toggling.
    always_comb begin
        prev_d    = prev_q;
        stable_d  = stable_q;
        present_d = present_q;
        pause_d   = pause_q;
        frame_d   = 1'b0;
        if (state_q == DONE) begin
            frame_d = 1'b1;
            if (shift_q == FRAME_ALL_PRESSED) begin
                present_d = 1'b0;
                stable_d  = '0;
                prev_d    = FRAME_ALL_PRESSED;
                pause_d   = 1'b0;
            end else begin
                present_d = 1'b1;
                if (shift_q == prev_q) begin
                    stable_d = shift_q;
                end
                prev_d = shift_q;
                // Select overrides a Start edge arriving in the same frame.
                if (stable_d[BTN_SELECT]) begin
                    pause_d = 1'b0;
                end else if (stable_d[BTN_START] && !stable_q[BTN_START]) begin
                    pause_d = ~pause_q;
                end
            end
        end
    end

    // Game-facing button levels, registered from the debounced frame.
    always_comb begin
        buttons_d = stable_q;
        restart_d = stable_q[BTN_SELECT];
        up_d      = stable_q[BTN_UP]    & ~stable_q[BTN_DOWN];
        down_d    = stable_q[BTN_DOWN]  & ~stable_q[BTN_UP];
        left_d    = stable_q[BTN_LEFT]  & ~stable_q[BTN_RIGHT];
        right_d   = stable_q[BTN_RIGHT] & ~stable_q[BTN_LEFT];
    end

    assign o_buttons = buttons_q;
    assign o_up      = up_q;
    assign o_down    = down_q;
    assign o_left    = left_q;
    assign o_right   = right_q;
    assign o_restart = restart_q;
    assign o_pause   = pause_q;
    assign o_present = present_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Randomized and directed bench for gamepad_reader against a frame-level model.
module tb_gamepad_reader;

    localparam int unsigned HALF = 4;
    // Poll sampled in cycle 0, DONE in cycle 18*HALF+1, strobe one cycle later.
    localparam int unsigned STROBE_CYCLE = 18 * HALF + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_poll = 1'b0;
    logic       i_pad_data;
    logic       o_pad_latch, o_pad_clk;
    logic       o_up, o_down, o_left, o_right, o_pause, o_restart, o_present, o_frame;
    logic [7:0] o_buttons;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Behavioural pad: 0 = normal, 1 = data tied low, 2 = data tied high.
    int         pad_mode    = 0;
    logic [7:0] pad_buttons = 8'h00;
    logic [7:0] pad_sr      = 8'h00;
    logic       pclk_prev   = 1'b1;

    // Frame-level reference state.
    logic [7:0] m_prev, m_stable;
    logic       m_pause, m_present;

    gamepad_reader #(
        .HALF_CYCLES (HALF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_poll      (i_poll),
        .i_pad_data  (i_pad_data),
        .o_pad_latch (o_pad_latch),
        .o_pad_clk   (o_pad_clk),
        .o_up        (o_up),
        .o_down      (o_down),
        .o_left      (o_left),
        .o_right     (o_right),
        .o_pause     (o_pause),
        .o_restart   (o_restart),
        .o_present   (o_present),
        .o_frame     (o_frame),
        .o_buttons   (o_buttons)
    );

    always #5 clk = ~clk;

    // Pad shift register: reloads while latched, advances on each pad-clock rise.
    always @(posedge clk) begin
        if (o_pad_latch)
            pad_sr <= pad_buttons;
        else if (o_pad_clk && !pclk_prev)
            pad_sr <= {1'b0, pad_sr[7:1]};
        pclk_prev <= o_pad_clk;
    end

    assign i_pad_data = (pad_mode == 1) ? 1'b0 :
                        (pad_mode == 2) ? 1'b1 : ~pad_sr[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_prev    = 8'h00;
        m_stable  = 8'h00;
        m_pause   = 1'b0;
        m_present = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] f);
        logic start_was;
        start_was = m_stable[3];
        if (f == 8'hFF) begin
            m_present = 1'b0;
            m_stable  = 8'h00;
            m_prev    = 8'hFF;
            m_pause   = 1'b0;
        end else begin
            m_present = 1'b1;
            if (f == m_prev) m_stable = f;
            m_prev = f;
            if (m_stable[2]) m_pause = 1'b0;
            else if (m_stable[3] && !start_was) m_pause = !m_pause;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic up_e, dn_e, lf_e, rt_e;
        up_e = m_stable[4] && !m_stable[5];
        dn_e = m_stable[5] && !m_stable[4];
        lf_e = m_stable[6] && !m_stable[7];
        rt_e = m_stable[7] && !m_stable[6];
        chk({tag, ".buttons"}, 32'(o_buttons), 32'(m_stable));
        chk({tag, ".dirs"}, 32'({o_up, o_down, o_left, o_right}), 32'({up_e, dn_e, lf_e, rt_e}));
        chk({tag, ".restart"}, 32'(o_restart), 32'(m_stable[2]));
        chk({tag, ".pause"}, 32'(o_pause), 32'(m_pause));
        chk({tag, ".present"}, 32'(o_present), 32'(m_present));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] pressed, input int mode,
                             input bit mid_poll);
        int unsigned k;
        logic [7:0]  f;
        pad_buttons = pressed;
        pad_mode    = mode;
        @(negedge clk) i_poll = 1'b1;
        @(negedge clk) i_poll = 1'b0;
        k = 1;
        while (o_frame !== 1'b1 && k < 300) begin
            i_poll = (mid_poll && (k == 20 || k == 40)) ? 1'b1 : 1'b0;
            @(negedge clk);
            k++;
        end
        i_poll = 1'b0;
        chk({tag, ".latency"}, k, STROBE_CYCLE);
        f = (mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : pressed;
        model_frame(f);
        @(negedge clk);
        chk({tag, ".strobe_len"}, 32'(o_frame), 32'd0);
        check_outputs(tag);
    endtask

    initial begin
        int unsigned reps;
        logic [7:0]  pat;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: pins parked, every output low.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle", 32'({o_pad_latch, o_pad_clk, o_buttons, o_up, o_down, o_left, o_right,
                             o_pause, o_restart, o_present, o_frame}),
                32'({1'b0, 1'b1, 8'h00, 8'h00}));
        end

        run_frame("up1", 8'h10, 0, 1'b0);
        chk("up1.o_up", 32'(o_up), 32'd0);
        run_frame("up2", 8'h10, 0, 1'b0);
        chk("up2.o_up", 32'(o_up), 32'd1);
        chk("up2.btn", 32'(o_buttons), 32'h10);
        run_frame("rel1", 8'h00, 0, 1'b0);
        run_frame("rel2", 8'h00, 0, 1'b0);
        chk("rel2.o_up", 32'(o_up), 32'd0);

        run_frame("ud1", 8'h30, 0, 1'b0);
        run_frame("ud2", 8'h30, 0, 1'b0);
        chk("ud2.btn", 32'(o_buttons), 32'h30);

        for (int i = 0; i < 4; i++) run_frame("start_hold", 8'h08, 0, 1'b0);
        chk("start_hold.pause", 32'(o_pause), 32'd1);
        run_frame("start_rel", 8'h00, 0, 1'b0);
        run_frame("start_rel", 8'h00, 0, 1'b0);
        run_frame("start_again", 8'h08, 0, 1'b0);
        run_frame("start_again", 8'h08, 0, 1'b0);
        chk("start_again.pause", 32'(o_pause), 32'd0);
        run_frame("gap", 8'h00, 0, 1'b0);
        run_frame("gap", 8'h00, 0, 1'b0);
        run_frame("st_sel", 8'h0C, 0, 1'b0);
        run_frame("st_sel", 8'h0C, 0, 1'b0);
        chk("st_sel.pause", 32'(o_pause), 32'd0);
        chk("st_sel.restart", 32'(o_restart), 32'd1);

        // Get paused, then unplug: pause must clear.
        run_frame("pre_unplug", 8'h00, 0, 1'b0);
        run_frame("pre_unplug", 8'h00, 0, 1'b0);
        run_frame("pre_unplug", 8'h08, 0, 1'b0);
        run_frame("pre_unplug", 8'h08, 0, 1'b0);
        run_frame("unplug", 8'h00, 1, 1'b0);
        chk("unplug.present", 32'(o_present), 32'd0);
        chk("unplug.pause", 32'(o_pause), 32'd0);
        run_frame("unplug2", 8'h00, 1, 1'b0);
        run_frame("tied_hi", 8'h00, 2, 1'b0);
        chk("tied_hi.present", 32'(o_present), 32'd1);
        run_frame("tied_hi2", 8'h00, 2, 1'b0);

        run_frame("mid_poll", 8'h81, 0, 1'b1);
        run_frame("mid_poll", 8'h81, 0, 1'b1);

        for (int i = 0; i < 15; i++) begin
            pat  = 8'($urandom_range(0, 255));
            reps = $urandom_range(1, 3);
            for (int r = 0; r < int'(reps); r++) run_frame("rand", pat, 0, 1'b0);
        end

        // Ensure some outputs are high, then reset in the middle of a LO phase.
        run_frame("pre_rst", 8'h44, 0, 1'b0);
        run_frame("pre_rst", 8'h44, 0, 1'b0);
        pad_buttons = 8'h10;
        pad_mode    = 0;
        @(negedge clk) i_poll = 1'b1;
        @(negedge clk) i_poll = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst.in_lo", 32'(o_pad_clk), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst.pins", 32'({o_pad_latch, o_pad_clk}), 32'b01);
        chk("rst.outs", 32'({o_buttons, o_up, o_down, o_left, o_right, o_pause, o_restart,
                             o_present, o_frame}), 32'd0);
        rst_n = 1'b1;
        model_reset();
        run_frame("post_rst", 8'h10, 0, 1'b0);
        run_frame("post_rst", 8'h10, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
